// File: rtl/alu_arbiter_pkg.sv
// Shared ALU widths, opcode encodings and arbiter FSM encodings.
// Also provides the opcode range check used when ALU_ARB_OPRN_CHECK_EN is defined.
package alu_arbiter_pkg;

  localparam int ALU_DATA_WIDTH        = 32;
  localparam int ALU_DATA_INDEX_LIMIT  = ALU_DATA_WIDTH - 1;
  localparam int ALU_OPRN_WIDTH        = 6;
  localparam int ALU_OPRN_INDEX_LIMIT  = ALU_OPRN_WIDTH - 1;

  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHR = 6'h04;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHL = 6'h05;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h09;

  typedef enum logic [1:0] {
    ALU_ARB_ST_IDLE = 2'd0,
    ALU_ARB_ST_EXEC = 2'd1,
    ALU_ARB_ST_RESP = 2'd2
  } alu_arb_state_t;

  function automatic logic oprn_is_valid(input logic [ALU_OPRN_WIDTH-1:0] oprn);
    return (oprn >= ALU_OPRN_ADD) && (oprn <= ALU_OPRN_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational project ALU: add/sub/mul/shifts/logic/unsigned set-less-than.
// All arithmetic wraps mod 2^DATA_WIDTH; unknown opcodes produce zero.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
) (
  output logic [DATA_WIDTH-1:0] result,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [OPRN_WIDTH-1:0] oprn
);

  // Opcode decode
  always_comb begin
    result = {DATA_WIDTH{1'b0}};
    case (oprn)
      ALU_OPRN_ADD: result = op1 + op2;
      ALU_OPRN_SUB: result = op1 - op2;
      ALU_OPRN_MUL: result = op1 * op2;
      ALU_OPRN_SHR: result = op1 >> op2;
      ALU_OPRN_SHL: result = op1 << op2;
      ALU_OPRN_AND: result = op1 & op2;
      ALU_OPRN_OR:  result = op1 | op2;
      ALU_OPRN_NOR: result = ~(op1 | op2);
      ALU_OPRN_SLT: result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      default:      result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Define ALU_ARB_OPRN_CHECK_EN to flag opcodes outside 0x01..0x09 via RSP_ERR.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID0,
  input  logic                  REQ_VALID1,
  output logic                  REQ_READY0,
  output logic                  REQ_READY1,
  input  logic [DATA_WIDTH-1:0] OP1_0,
  input  logic [DATA_WIDTH-1:0] OP1_1,
  input  logic [DATA_WIDTH-1:0] OP2_0,
  input  logic [DATA_WIDTH-1:0] OP2_1,
  input  logic [OPRN_WIDTH-1:0] OPRN_0,
  input  logic [OPRN_WIDTH-1:0] OPRN_1,
  output logic                  RSP_VALID0,
  output logic                  RSP_VALID1,
  input  logic                  RSP_READY0,
  input  logic                  RSP_READY1,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  RSP_ERR
);

  alu_arb_state_t          state_r;
  alu_arb_state_t          next_state_s;
  logic                    prio_r;
  logic                    owner_r;
  logic [DATA_WIDTH-1:0]   op1_r;
  logic [DATA_WIDTH-1:0]   op2_r;
  logic [OPRN_WIDTH-1:0]   oprn_r;
  logic [DATA_WIDTH-1:0]   result_r;
  logic                    err_r;
  logic                    rsp_valid0_r;
  logic                    rsp_valid1_r;
  logic [DATA_WIDTH-1:0]   alu_result_s;
  logic                    hs_s;
  logic                    rsp_hs_s;
  logic                    oprn_bad_s;

  alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OPRN_WIDTH (OPRN_WIDTH)
  ) u_alu (
    .result (alu_result_s),
    .op1    (op1_r),
    .op2    (op2_r),
    .oprn   (oprn_r)
  );

`ifdef ALU_ARB_OPRN_CHECK_EN
  assign oprn_bad_s = ~oprn_is_valid(oprn_r);
`else
  assign oprn_bad_s = 1'b0;
`endif

  // Round-robin grant: a lone request wins, contention goes to prio
  always_comb begin
    REQ_READY0 = 1'b0;
    REQ_READY1 = 1'b0;
    if (state_r == ALU_ARB_ST_IDLE) begin
      REQ_READY0 = REQ_VALID0 & (~REQ_VALID1 | (prio_r == 1'b0));
      REQ_READY1 = REQ_VALID1 & (~REQ_VALID0 | (prio_r == 1'b1));
    end else begin
      REQ_READY0 = 1'b0;
      REQ_READY1 = 1'b0;
    end
  end

  assign hs_s     = REQ_READY0 | REQ_READY1;
  assign rsp_hs_s = (rsp_valid0_r & RSP_READY0) | (rsp_valid1_r & RSP_READY1);

  // FSM next-state
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ALU_ARB_ST_IDLE: begin
        if (hs_s) next_state_s = ALU_ARB_ST_EXEC;
        else      next_state_s = ALU_ARB_ST_IDLE;
      end
      ALU_ARB_ST_EXEC: next_state_s = ALU_ARB_ST_RESP;
      ALU_ARB_ST_RESP: begin
        if (rsp_hs_s) next_state_s = ALU_ARB_ST_IDLE;
        else          next_state_s = ALU_ARB_ST_RESP;
      end
      default: next_state_s = ALU_ARB_ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= ALU_ARB_ST_IDLE;
    else      state_r <= next_state_s;
  end

  // Command capture; prio moves to the requester that was not granted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op1_r   <= {DATA_WIDTH{1'b0}};
      op2_r   <= {DATA_WIDTH{1'b0}};
      oprn_r  <= {OPRN_WIDTH{1'b0}};
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
    end else if (REQ_READY1) begin
      op1_r   <= OP1_1;
      op2_r   <= OP2_1;
      oprn_r  <= OPRN_1;
      owner_r <= 1'b1;
      prio_r  <= 1'b0;
    end else if (REQ_READY0) begin
      op1_r   <= OP1_0;
      op2_r   <= OP2_0;
      oprn_r  <= OPRN_0;
      owner_r <= 1'b0;
      prio_r  <= 1'b1;
    end
  end

  // Response registers: loaded leaving EXEC, held until the owner accepts
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      result_r     <= {DATA_WIDTH{1'b0}};
      err_r        <= 1'b0;
      rsp_valid0_r <= 1'b0;
      rsp_valid1_r <= 1'b0;
    end else if (state_r == ALU_ARB_ST_EXEC) begin
      result_r     <= oprn_bad_s ? {DATA_WIDTH{1'b0}} : alu_result_s;
      err_r        <= oprn_bad_s;
      rsp_valid0_r <= ~owner_r;
      rsp_valid1_r <= owner_r;
    end else if (rsp_hs_s) begin
      rsp_valid0_r <= 1'b0;
      rsp_valid1_r <= 1'b0;
    end
  end

  assign RSP_VALID0 = rsp_valid0_r;
  assign RSP_VALID1 = rsp_valid1_r;
  assign RESULT     = result_r;
  assign RSP_ERR    = err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses at each
// command handshake, a monitor pops and compares at each response handshake.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic        owner;
    logic [31:0] result;
    logic        err;
    logic        chk_res;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] op1 [2];
  logic [31:0] op2 [2];
  logic [5:0]  oprn [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] RESULT;
  logic        RSP_ERR;

  exp_t sb[$];
  int   grant_log[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  alu_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID0 (req_valid[0]),
    .REQ_VALID1 (req_valid[1]),
    .REQ_READY0 (req_ready[0]),
    .REQ_READY1 (req_ready[1]),
    .OP1_0      (op1[0]),
    .OP1_1      (op1[1]),
    .OP2_0      (op2[0]),
    .OP2_1      (op2[1]),
    .OPRN_0     (oprn[0]),
    .OPRN_1     (oprn[1]),
    .RSP_VALID0 (rsp_valid[0]),
    .RSP_VALID1 (rsp_valid[1]),
    .RSP_READY0 (rsp_ready[0]),
    .RSP_READY1 (rsp_ready[1]),
    .RESULT     (RESULT),
    .RSP_ERR    (RSP_ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command on requester r; push its expected response at the handshake.
  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] op, input logic [31:0] exp_res,
                      input logic exp_err, input logic chk_res);
    bit   got = 1'b0;
    exp_t e;
    req_valid[r] = 1'b1;
    op1[r] = a;
    op2[r] = b;
    oprn[r] = op;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge CLK);
      if (req_ready[r]) begin
        got = 1'b1;
        e.owner = r[0];
        e.result = exp_res;
        e.err = exp_err;
        e.chk_res = chk_res;
        sb.push_back(e);
        grant_log.push_back(r);
      end
    end
    check("req_handshake", 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    req_valid[r] = 1'b0;
    op1[r] = $urandom;
    op2[r] = $urandom;
    oprn[r] = 6'($urandom);
  endtask

  // Send on requester 0 and check the response appears exactly two cycles later.
  task automatic send_lat(input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] op, input logic [31:0] exp_res);
    send(0, a, b, op, exp_res, 1'b0, 1'b1);
    @(negedge CLK);
    check("lat_exec_rv0", 32'(rsp_valid[0]), 32'd0);
    @(negedge CLK);
    check("lat_resp_rv0", 32'(rsp_valid[0]), 32'd1);
    check("lat_resp_rv1", 32'(rsp_valid[1]), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    sb.delete();
    grant_log.delete();
    #1;
    check("rst_rv0", 32'(rsp_valid[0]), 32'd0);
    check("rst_rv1", 32'(rsp_valid[1]), 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_err", 32'(RSP_ERR), 32'd0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares every response handshake against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (rsp_valid[0] | rsp_valid[1])
          check("rsp_onehot", 32'(rsp_valid[0] & rsp_valid[1]), 32'd0);
        for (int r = 0; r < 2; r++) begin
          if (rsp_valid[r] && rsp_ready[r]) begin
            if (sb.size() == 0) begin
              check("unexpected_rsp", 32'(r), 32'hFFFF_FFFF);
            end else begin
              e = sb.pop_front();
              check("rsp_owner", 32'(r), 32'(e.owner));
              if (e.chk_res) check("rsp_result", RESULT, e.result);
              check("rsp_err", 32'(RSP_ERR), 32'(e.err));
            end
          end
        end
      end
    end
  end

  logic [31:0] t_a   [10] = '{32'hFFFF_FFFF, 32'h0, 32'h0001_0000, 32'h1, 32'h0000_F0F0,
                             32'h0000_F0F0, 32'h0, 32'h3, 32'h5, 32'hFFFF_FFFF};
  logic [31:0] t_b   [10] = '{32'h1, 32'h1, 32'h0001_0000, 32'd32, 32'h0000_FF00,
                             32'h0000_0F00, 32'h0, 32'h5, 32'h3, 32'h1};
  logic [5:0]  t_op  [10] = '{6'h01, 6'h02, 6'h03, 6'h05, 6'h06,
                             6'h07, 6'h08, 6'h09, 6'h09, 6'h09};
  logic [31:0] t_exp [10] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_F000,
                             32'h0000_FFF0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0};

  initial begin : stim
    logic exp_err;
    logic exp_chk;
    bit   got;
    for (int r = 0; r < 2; r++) begin
      req_valid[r] = 1'b0;
      op1[r] = 32'd0;
      op2[r] = 32'd0;
      oprn[r] = 6'd0;
      rsp_ready[r] = 1'b1;
    end
    #2 RST = 1'b0;
    #10;
    check("init_rv0", 32'(rsp_valid[0]), 32'd0);
    check("init_rv1", 32'(rsp_valid[1]), 32'd0);
    check("init_result", RESULT, 32'd0);
    check("init_err", 32'(RSP_ERR), 32'd0);
    check("init_rdy0", 32'(req_ready[0]), 32'd0);
    #11 RST = 1'b1;
    @(posedge CLK);
    #1;

    // Single requester: 15 + 3
    send_lat(32'd15, 32'd3, ALU_OPRN_ADD, 32'd18);
    drain();

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    fork
      send(0, 32'd15, 32'd5, ALU_OPRN_SUB, 32'd10, 1'b0, 1'b1);
      send(1, 32'd3, 32'd3, ALU_OPRN_MUL, 32'd9, 1'b0, 1'b1);
    join
    drain();
    check("t2_ngrant", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("t2_grant0", 32'(grant_log[0]), 32'd0);
      check("t2_grant1", 32'(grant_log[1]), 32'd1);
    end
    grant_log.delete();

    // Continuous contention: grants must alternate starting with req0
    fork
      begin
        for (int k = 0; k < 6; k++) send(0, 32'd8, 32'd2, ALU_OPRN_SHR, 32'd2, 1'b0, 1'b1);
      end
      begin
        for (int k = 0; k < 6; k++) send(1, 32'd1, 32'd4, ALU_OPRN_SHL, 32'd16, 1'b0, 1'b1);
      end
    join
    drain();
    check("t3_ngrant", 32'(grant_log.size()), 32'd12);
    for (int i = 0; i < grant_log.size(); i++)
      check("t3_alternate", 32'(grant_log[i]), 32'(i % 2));
    grant_log.delete();

    // Directed opcode table on requester 1 (wraparound and boundary cases)
    for (int i = 0; i < 10; i++) begin
      send(1, t_a[i], t_b[i], t_op[i], t_exp[i], 1'b0, 1'b1);
      drain();
    end

    // Backpressure on requester 0 while requester 1 waits
    rsp_ready[0] = 1'b0;
    send(0, 32'd1, 32'd3, ALU_OPRN_SHL, 32'd8, 1'b0, 1'b1);
    fork
      send(1, 32'd2, 32'd2, ALU_OPRN_ADD, 32'd4, 1'b0, 1'b1);
    join_none
    @(negedge CLK);
    check("bp_exec_rdy1", 32'(req_ready[1]), 32'd0);
    repeat (5) begin
      @(negedge CLK);
      check("bp_rv0", 32'(rsp_valid[0]), 32'd1);
      check("bp_result", RESULT, 32'd8);
      check("bp_rdy1", 32'(req_ready[1]), 32'd0);
    end
    @(posedge CLK);
    #1;
    rsp_ready[0] = 1'b1;
    wait fork;
    drain();

    // Out-of-range opcodes
`ifdef ALU_ARB_OPRN_CHECK_EN
    exp_err = 1'b1;
    exp_chk = 1'b1;
`else
    exp_err = 1'b0;
    exp_chk = 1'b0;
`endif
    send(0, 32'd7, 32'd7, 6'h00, 32'd0, exp_err, exp_chk);
    drain();
    send(1, 32'd7, 32'd7, 6'h3F, 32'd0, exp_err, exp_chk);
    drain();
    send(0, 32'd7, 32'd7, ALU_OPRN_AND, 32'd7, 1'b0, 1'b1);
    drain();

    // Reset during EXEC of 3 * 3: command dropped, no response afterwards
    got = 1'b0;
    req_valid[1] = 1'b1;
    op1[1] = 32'd3;
    op2[1] = 32'd3;
    oprn[1] = ALU_OPRN_MUL;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      if (req_ready[1]) got = 1'b1;
    end
    check("rst_hs", 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    req_valid[1] = 1'b0;
    RST = 1'b0;
    #1;
    check("midrst_rv0", 32'(rsp_valid[0]), 32'd0);
    check("midrst_rv1", 32'(rsp_valid[1]), 32'd0);
    check("midrst_result", RESULT, 32'd0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("postrst_rv0", 32'(rsp_valid[0]), 32'd0);
      check("postrst_rv1", 32'(rsp_valid[1]), 32'd0);
    end
    @(posedge CLK);
    #1;
    send_lat(32'd0, 32'd3, ALU_OPRN_MUL, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
